// File: rtl/gpio_access_arbiter10_pkg.sv
// Shared types and register map for the gpio_lite access path.
// Purely declarative: no logic and no latency.
// No flow control.
package gpio_pkg10;

    localparam int GPIO_ADDR_W = 6;
    localparam int GPIO_DATA_W = 16;

    localparam logic [GPIO_ADDR_W-1:0] GPR_DATA_OUT   = 6'h04;
    localparam logic [GPIO_ADDR_W-1:0] GPR_DIR        = 6'h08;
    localparam logic [GPIO_ADDR_W-1:0] GPR_INT_EN     = 6'h0C;
    localparam logic [GPIO_ADDR_W-1:0] GPR_PIN_IN     = 6'h10;
    // Read-to-clear register; must never be read speculatively.
    localparam logic [GPIO_ADDR_W-1:0] GPR_INT_STATUS = 6'h20;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ISSUE   = 2'b01,
        ST_CAPTURE = 2'b10
    } arb_state_t;

    function automatic logic [1:0] grant_vec(input logic who);
        return who ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/gpio_access_arbiter10_if.sv
// Requester and subunit signals of the gpio access arbiter.
// Wiring only; no latency.
// Requesters hold req until ack; the subunit side has no backpressure.
interface gpio_access_arbiter10_if
    import gpio_pkg10::*;
#(
    parameter int ADDR_W = GPIO_ADDR_W,
    parameter int DATA_W = GPIO_DATA_W
) ();

    logic [1:0]        req_i;
    logic [1:0]        we_i;
    logic [1:0]        lock_i;
    logic [ADDR_W-1:0] addr0_i;
    logic [ADDR_W-1:0] addr1_i;
    logic [DATA_W-1:0] wdata0_i;
    logic [DATA_W-1:0] wdata1_i;
    logic [1:0]        ack_o;
    logic [DATA_W-1:0] rdata_o;
    logic              busy_o;
    logic              sub_read;
    logic              sub_write;
    logic [ADDR_W-1:0] sub_addr;
    logic [DATA_W-1:0] sub_wdata;
    logic [DATA_W-1:0] sub_rdata;

    modport slave (
        input  req_i, we_i, lock_i, addr0_i, addr1_i, wdata0_i, wdata1_i, sub_rdata,
        output ack_o, rdata_o, busy_o, sub_read, sub_write, sub_addr, sub_wdata
    );

    modport master (
        output req_i, we_i, lock_i, addr0_i, addr1_i, wdata0_i, wdata1_i, sub_rdata,
        input  ack_o, rdata_o, busy_o, sub_read, sub_write, sub_addr, sub_wdata
    );

endinterface

// File: rtl/gpio_access_arbiter10_rr_pick.sv
// Two-way winner picker: round-robin against last_grant, or requester 0 first.
// Combinational, zero latency.
// No flow control; vld simply mirrors any request.
module gpio_rr_pick10 #(
    parameter bit FIXED_PRI = 1'b0
) (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       vld,
    output logic       win
);

    always_comb begin
        vld = |req;
        win = 1'b0;
        if (req == 2'b11) begin
            win = FIXED_PRI ? 1'b0 : ~last_grant;
        end else begin
            win = req[1];
        end
    end

endmodule

// File: rtl/gpio_access_arbiter10.sv
// Serialises two requesters onto one gpio_lite register port.
// Latency: request seen in cycle N, strobe at N+1, ack/rdata at N+2; one access per 3 cycles.
// Backpressure: requesters hold req until their ack pulse; the loser simply waits.
module gpio_access_arbiter10
    import gpio_pkg10::*;
#(
    parameter int ADDR_W    = GPIO_ADDR_W,
    parameter int DATA_W    = GPIO_DATA_W,
    parameter bit FIXED_PRI = 1'b0
) (
    input logic                    pclk10,
    input logic                    n_reset10,
    gpio_access_arbiter10_if.slave bus
);

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic              grant;

    logic              owner_q;
    logic              we_q;
    logic              last_grant_q;
    logic              lock_held_q;
    logic              sub_read_q;
    logic              sub_write_q;
    logic [ADDR_W-1:0] sub_addr_q;
    logic [DATA_W-1:0] sub_wdata_q;
    logic [1:0]        ack_q;

    logic              lock_live;
    logic [1:0]        pick_req;
    logic              pick_vld;
    logic              pick_win;

    // A held lock only counts while its owner is still asking; otherwise
    // both requesters compete normally in the same IDLE cycle.
    assign lock_live = lock_held_q & bus.req_i[last_grant_q];
    assign pick_req  = lock_live ? grant_vec(last_grant_q) : bus.req_i;

    gpio_rr_pick10 #(
        .FIXED_PRI (FIXED_PRI)
    ) u_pick (
        .req        (pick_req),
        .last_grant (last_grant_q),
        .vld        (pick_vld),
        .win        (pick_win)
    );

    always_ff @(posedge pclk10 or negedge n_reset10) begin
        if (!n_reset10) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    grant   = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE:   state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk10 or negedge n_reset10) begin
        if (!n_reset10) begin
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            last_grant_q <= 1'b1;
            lock_held_q  <= 1'b0;
            sub_read_q   <= 1'b0;
            sub_write_q  <= 1'b0;
            sub_addr_q   <= '0;
            sub_wdata_q  <= '0;
            ack_q        <= 2'b00;
        end else begin
            sub_read_q  <= 1'b0;
            sub_write_q <= 1'b0;
            ack_q       <= 2'b00;

            // Address/data are latched straight into the subunit port so
            // they hold their last value once the strobe drops.
            if (grant) begin
                owner_q     <= pick_win;
                we_q        <= bus.we_i[pick_win];
                sub_read_q  <= ~bus.we_i[pick_win];
                sub_write_q <= bus.we_i[pick_win];
                sub_addr_q  <= pick_win ? bus.addr1_i  : bus.addr0_i;
                sub_wdata_q <= pick_win ? bus.wdata1_i : bus.wdata0_i;
            end

            if (state_q == ST_ISSUE) begin
                ack_q <= grant_vec(owner_q);
            end

            if (state_q == ST_CAPTURE) begin
                last_grant_q <= owner_q;
                lock_held_q  <= bus.lock_i[owner_q];
            end else if (state_q == ST_IDLE && lock_held_q && !bus.req_i[last_grant_q]) begin
                lock_held_q <= 1'b0;
            end
        end
    end

    // sub_rdata is the subunit's registered output and is only valid in the
    // capture cycle, so it is gated through rather than re-registered.
    assign bus.rdata_o   = (|ack_q && !we_q) ? bus.sub_rdata : '0;
    assign bus.ack_o     = ack_q;
    assign bus.busy_o    = (state_q != ST_IDLE);
    assign bus.sub_read  = sub_read_q;
    assign bus.sub_write = sub_write_q;
    assign bus.sub_addr  = sub_addr_q;
    assign bus.sub_wdata = sub_wdata_q;

    a_req_held_until_ack: assert property (
        @(posedge pclk10) disable iff (!n_reset10)
        (state_q != ST_IDLE) |-> bus.req_i[owner_q]
    );

    a_single_strobe: assert property (
        @(posedge pclk10) disable iff (!n_reset10)
        !(sub_read_q && sub_write_q)
    );

endmodule

// File: tb/tb_gpio_access_arbiter10.sv
// Bench for gpio_access_arbiter10: scoreboard of expected responses per requester,
// checked by an independent monitor against a behavioural subunit and reference model.
module tb_gpio_access_arbiter10;
    import gpio_pkg10::*;

    localparam logic [15:0] PIN_IN = 16'hA5A5;

    typedef struct {
        bit          we;
        logic [5:0]  addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } exp_t;

    logic pclk10;
    logic n_reset10;
    int   checks;
    int   failures;
    int   cyc;

    gpio_access_arbiter10_if ifc ();
    gpio_access_arbiter10_if ifc_fp ();

    gpio_access_arbiter10 #(.FIXED_PRI(1'b0)) dut (
        .pclk10    (pclk10),
        .n_reset10 (n_reset10),
        .bus       (ifc)
    );

    gpio_access_arbiter10 #(.FIXED_PRI(1'b1)) dut_fp (
        .pclk10    (pclk10),
        .n_reset10 (n_reset10),
        .bus       (ifc_fp)
    );

    // Requester drive variables
    logic        r0_req, r0_we, r0_lock, r1_req, r1_we, r1_lock;
    logic [5:0]  r0_addr, r1_addr;
    logic [15:0] r0_wdata, r1_wdata;
    logic        fp_req0, fp_req1;

    assign ifc.req_i    = {r1_req, r0_req};
    assign ifc.we_i     = {r1_we, r0_we};
    assign ifc.lock_i   = {r1_lock, r0_lock};
    assign ifc.addr0_i  = r0_addr;
    assign ifc.addr1_i  = r1_addr;
    assign ifc.wdata0_i = r0_wdata;
    assign ifc.wdata1_i = r1_wdata;

    assign ifc_fp.req_i    = {fp_req1, fp_req0};
    assign ifc_fp.we_i     = 2'b00;
    assign ifc_fp.lock_i   = 2'b00;
    assign ifc_fp.addr0_i  = 6'h05;
    assign ifc_fp.addr1_i  = 6'h06;
    assign ifc_fp.wdata0_i = 16'h0000;
    assign ifc_fp.wdata1_i = 16'h0000;

    // Behavioural gpio_lite subunit: registered rdata, INT_STATUS clears on read.
    logic [15:0] sub_mem [64] = '{default: 16'h0000};
    logic [15:0] sub_rdata_r = 16'h0000;
    logic [15:0] int_st = 16'h0000;
    logic        int_set;
    logic [15:0] fp_rdata = 16'h0000;

    always @(posedge pclk10) begin
        if (ifc.sub_write) sub_mem[ifc.sub_addr] <= ifc.sub_wdata;
        if (ifc.sub_read) begin
            if (ifc.sub_addr == GPR_PIN_IN)          sub_rdata_r <= PIN_IN;
            else if (ifc.sub_addr == GPR_INT_STATUS) sub_rdata_r <= int_st;
            else                                     sub_rdata_r <= sub_mem[ifc.sub_addr];
        end
    end

    always @(posedge pclk10) begin
        if (int_set) int_st <= 16'h0001;
        else if (ifc.sub_read && ifc.sub_addr == GPR_INT_STATUS) int_st <= 16'h0000;
    end

    always @(posedge pclk10) begin
        if (ifc_fp.sub_read) fp_rdata <= {10'b0, ifc_fp.sub_addr};
    end

    assign ifc.sub_rdata    = sub_rdata_r;
    assign ifc_fp.sub_rdata = fp_rdata;

    initial pclk10 = 1'b0;
    always #5 pclk10 = ~pclk10;
    always @(posedge pclk10) cyc <= cyc + 1;

    // Reference model and scoreboard
    logic [15:0] mdl_mem [64] = '{default: 16'h0000};
    logic [15:0] mdl_int = 16'h0000;
    exp_t        exp_q0[$];
    exp_t        exp_q1[$];
    int          exp_order[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, req);
        end
    endtask

    task automatic issue_exp(input int r, input bit we, input logic [5:0] a, input logic [15:0] wd);
        exp_t e;
        e.we = we; e.addr = a; e.wdata = wd; e.rdata = 16'h0000;
        if (we)                       mdl_mem[a] = wd;
        else if (a == GPR_PIN_IN)     e.rdata = PIN_IN;
        else if (a == GPR_INT_STATUS) begin e.rdata = mdl_int; mdl_int = 16'h0000; end
        else                          e.rdata = mdl_mem[a];
        if (r == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    // Caller is at posedge+1; returns at posedge+1 after the ack with req dropped.
    task automatic access(input int r, input bit we, input logic [5:0] a, input logic [15:0] wd, input bit lk);
        bit got;
        issue_exp(r, we, a, wd);
        if (r == 0) begin r0_req = 1; r0_we = we; r0_addr = a; r0_wdata = wd; r0_lock = lk; end
        else        begin r1_req = 1; r1_we = we; r1_addr = a; r1_wdata = wd; r1_lock = lk; end
        got = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge pclk10);
            if (ifc.ack_o[r]) got = 1;
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL ack_timeout req%0d actual=no_ack expected=ack", r);
        end
        @(posedge pclk10); #1;
        if (r == 0) begin r0_req = 0; r0_lock = 0; end
        else        begin r1_req = 0; r1_lock = 0; end
    endtask

    // Monitor: every ack pops the owner's expected entry and checks the strobe that fed it.
    int          pend;
    int          st_cyc;
    bit          st_we;
    logic [5:0]  st_addr;
    logic [15:0] st_wdata;
    exp_t        me;
    logic        who;

    initial begin
        pend = 0;
        forever begin
            @(negedge pclk10);
            if (!n_reset10) begin
                pend = 0;
            end else begin
                if (ifc.sub_read || ifc.sub_write) begin
                    chk("strobe_exclusive", {31'b0, ifc.sub_read & ifc.sub_write}, 0);
                    pend++;
                    st_cyc = cyc; st_we = ifc.sub_write;
                    st_addr = ifc.sub_addr; st_wdata = ifc.sub_wdata;
                end
                if (ifc.ack_o != 2'b00) begin
                    who = ifc.ack_o[1];
                    chk("ack_onehot", $countones(ifc.ack_o), 1);
                    chk("strobes_per_access", pend, 1);
                    chk("strobe_to_ack_cycles", cyc - st_cyc, 1);
                    if (exp_order.size() > 0) chk("grant_order", {31'b0, who}, exp_order.pop_front());
                    if ((who == 0 && exp_q0.size() == 0) || (who == 1 && exp_q1.size() == 0)) begin
                        checks++; failures++;
                        $display("FAIL unexpected_ack actual=%b expected=none", ifc.ack_o);
                    end else begin
                        me = (who == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        chk("access_we", {31'b0, st_we}, {31'b0, me.we});
                        chk("access_addr", {26'b0, st_addr}, {26'b0, me.addr});
                        if (me.we) chk("access_wdata", {16'b0, st_wdata}, {16'b0, me.wdata});
                        chk("rdata", {16'b0, ifc.rdata_o}, {16'b0, me.rdata});
                    end
                    pend = 0;
                end else begin
                    chk("rdata_zero_without_ack", {16'b0, ifc.rdata_o}, 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1;
        bit got;
        checks = 0; failures = 0; cyc = 0;
        n_reset10 = 0; int_set = 0;
        r0_req = 0; r0_we = 0; r0_lock = 0; r0_addr = 0; r0_wdata = 0;
        r1_req = 0; r1_we = 0; r1_lock = 0; r1_addr = 0; r1_wdata = 0;
        fp_req0 = 0; fp_req1 = 0;

        repeat (3) @(negedge pclk10);
        chk("rst_ack", {30'b0, ifc.ack_o}, 0);
        chk("rst_busy", {31'b0, ifc.busy_o}, 0);
        chk("rst_strobes", {30'b0, ifc.sub_read, ifc.sub_write}, 0);
        chk("rst_sub_addr_wdata", {10'b0, ifc.sub_addr, ifc.sub_wdata}, 0);
        chk("rst_rdata", {16'b0, ifc.rdata_o}, 0);
        @(posedge pclk10); #1 n_reset10 = 1;
        @(posedge pclk10); #1;

        // Ties from reset: req0 first, then req1; the following tie again goes to req0.
        exp_order.push_back(0); exp_order.push_back(1);
        exp_order.push_back(0); exp_order.push_back(1);
        repeat (2) fork
            access(0, 0, GPR_PIN_IN, 16'h0, 0);
            access(1, 0, GPR_PIN_IN, 16'h0, 0);
        join

        // Single write: strobe exactly at N+1, ack at N+2, address holds afterwards.
        issue_exp(0, 1, GPR_DATA_OUT, 16'h00F0);
        r0_req = 1; r0_we = 1; r0_addr = GPR_DATA_OUT; r0_wdata = 16'h00F0;
        @(negedge pclk10);
        chk("t1_idle_no_strobe", {30'b0, ifc.sub_write, ifc.busy_o}, 0);
        @(negedge pclk10);
        chk("t1_issue_write", {30'b0, ifc.sub_write, ifc.sub_read}, 2);
        chk("t1_issue_addr_data", {10'b0, ifc.sub_addr, ifc.sub_wdata}, {10'b0, 6'h04, 16'h00F0});
        chk("t1_issue_busy", {31'b0, ifc.busy_o}, 1);
        @(negedge pclk10);
        chk("t1_ack", {30'b0, ifc.ack_o}, 1);
        @(posedge pclk10); #1 r0_req = 0;
        @(negedge pclk10);
        chk("t1_after_strobe_low", {30'b0, ifc.sub_write, ifc.ack_o[0]}, 0);
        chk("t1_addr_holds", {26'b0, ifc.sub_addr}, 32'h04);
        @(posedge pclk10); #1;

        // INT_STATUS read-to-clear through requester 1.
        int_set = 1; mdl_int = 16'h0001;
        @(posedge pclk10); #1 int_set = 0;
        access(1, 0, GPR_INT_STATUS, 16'h0, 0);
        access(1, 0, GPR_INT_STATUS, 16'h0, 0);

        // Locked read-modify-write by req0 keeps req1 waiting.
        exp_order.push_back(0); exp_order.push_back(0); exp_order.push_back(1);
        fork
            begin
                access(0, 0, GPR_INT_EN, 16'h0, 1);
                access(0, 1, GPR_INT_EN, 16'hCAFE, 0);
            end
            access(1, 0, 6'h30, 16'h0, 0);
        join

        // Reset during ISSUE: strobe drops at once, no ack, write lost, req0 wins next tie.
        access(0, 0, GPR_DATA_OUT, 16'h0, 0);
        r0_req = 1; r0_we = 1; r0_addr = GPR_DIR; r0_wdata = 16'hBEEF;
        @(negedge pclk10);
        @(negedge pclk10);
        chk("t5_issue_write", {31'b0, ifc.sub_write}, 1);
        #2 n_reset10 = 0;
        #1;
        chk("t5_reset_strobe_drop", {30'b0, ifc.sub_write, ifc.busy_o}, 0);
        chk("t5_reset_no_ack", {30'b0, ifc.ack_o}, 0);
        @(posedge pclk10); #1 r0_req = 0; r0_we = 0;
        @(posedge pclk10); #1 n_reset10 = 1;
        @(posedge pclk10); #1;
        exp_order.push_back(0); exp_order.push_back(1);
        fork
            access(0, 0, GPR_DIR, 16'h0, 0);
            access(1, 0, 6'h31, 16'h0, 0);
        join

        // Randomised traffic on disjoint address windows, random locks and gaps.
        fork
            for (int i = 0; i < 40; i++) begin
                access(0, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 15)),
                       16'($urandom), $urandom_range(0, 3) == 0);
                repeat ($urandom_range(0, 3)) begin @(posedge pclk10); #1; end
            end
            for (int i = 0; i < 40; i++) begin
                access(1, 1'($urandom_range(0, 1)), 6'(6'h30 + $urandom_range(0, 15)),
                       16'($urandom), $urandom_range(0, 3) == 0);
                repeat ($urandom_range(0, 3)) begin @(posedge pclk10); #1; end
            end
        join

        // Fixed priority: req0 requesting continuously starves req1.
        c0 = 0; c1 = 0;
        fp_req0 = 1; fp_req1 = 1;
        for (int i = 0; i < 60; i++) begin
            @(negedge pclk10);
            if (ifc_fp.ack_o[0]) begin
                c0++;
                chk("fp_rdata", {16'b0, ifc_fp.rdata_o}, 32'h0005);
            end
            if (ifc_fp.ack_o[1]) c1++;
        end
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge pclk10);
            if (ifc_fp.ack_o[0]) got = 1;
        end
        chk("fp_final_ack_seen", {31'b0, got}, 1);
        @(posedge pclk10); #1 fp_req0 = 0; fp_req1 = 0;
        chk("fp_req0_acks", c0, 20);
        chk("fp_req1_starved", c1, 0);

        repeat (10) @(posedge pclk10);
        chk("q0_drained", exp_q0.size(), 0);
        chk("q1_drained", exp_q1.size(), 0);
        chk("order_drained", exp_order.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
